fetch_seq: RTL and testbench

Fetch-stage sequencer for the five-stage MIPS pipeline. It owns the F-stage PC register and the F/D pipeline register, and drives the instruction-memory request handshake. It computes the next PC from the D-stage control-flow decision and stalls cleanly when memory is slow or the hazard unit holds D. Branch/jump targets are resolved in D with one architectural delay slot; the slot is never flushed.

---
 rtl/fetch_seq_pkg.sv | 28 ++
 rtl/fetch_seq_npc.sv | 38 +++
 rtl/fetch_seq.sv | 97 +++++++++
 tb/tb_fetch_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch-stage sequencer:
// next-PC op codes, FSM states and reset PC.
package fetch_seq_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BR  = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_HELD = 1'b1
  } fs_state_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fd_t;

  function automatic logic [31:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_seq_npc.sv
// Combinational next-PC select and illegal-op detect.
// Redirects apply only when D holds a real instruction.
module fetch_seq_npc
  import fetch_seq_pkg::*;
(
  input  logic [31:0] i_pc_f,
  input  logic [25:0] i_ir_d,
  input  logic        i_valid_d,
  input  logic [2:0]  i_op,
  input  logic        i_cmp_zero,
  input  logic [31:0] i_gpr_rs,
  output logic [31:0] o_npc,
  output logic        o_illegal
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;

  assign w_pc4    = i_pc_f + 32'd4;
  assign w_br_tgt = i_pc_f + br_off(i_ir_d[15:0]);
  assign w_j_tgt  = {i_pc_f[31:28], i_ir_d, 2'b00};

  always_comb begin
    o_npc     = w_pc4;
    o_illegal = 1'b0;
    if (i_valid_d) begin
      unique case (i_op)
        NPC_SEQ: o_npc = w_pc4;
        NPC_BR:  o_npc = i_cmp_zero ? w_br_tgt : w_pc4;
        NPC_J:   o_npc = w_j_tgt;
        NPC_JR:  o_npc = i_gpr_rs;
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// F-stage PC, one-entry fetch buffer and F/D register
// with the imem request handshake.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic [2:0]  npc_op_d,
  input  logic        cmp_zero_d,
  input  logic [31:0] gpr_rs_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        fetch_stall,
  output logic        npc_err
);

  fs_state_e   r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_buf;
  fd_t         r_fd;
  logic        r_valid_d;
  logic        r_err;

  logic [31:0] w_npc;
  logic        w_illegal;
  logic        w_req;
  logic        w_done;
  logic        w_adv;
  logic        w_cap;
  logic [31:0] w_word;

  fetch_seq_npc u_npc (
    .i_pc_f     (r_pc_f),
    .i_ir_d     (r_fd.ir[25:0]),
    .i_valid_d  (r_valid_d),
    .i_op       (npc_op_d),
    .i_cmp_zero (cmp_zero_d),
    .i_gpr_rs   (gpr_rs_d),
    .o_npc      (w_npc),
    .o_illegal  (w_illegal)
  );

  assign w_req  = (r_state == ST_REQ);
  assign w_done = w_req && imem_ready;
  // D only advances on a completed fetch, so redirects are never lost
  assign w_adv  = !stall_d && (w_done || !w_req);
  assign w_cap  = w_done && stall_d;
  assign w_word = w_req ? imem_rdata : r_buf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_REQ;
      r_pc_f    <= RESET_PC;
      r_buf     <= '0;
      r_fd      <= '0;
      r_valid_d <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_adv) begin
        r_fd.ir   <= w_word;
        r_fd.pc   <= r_pc_f;
        r_valid_d <= 1'b1;
        r_pc_f    <= w_npc;
        r_state   <= ST_REQ;
      end else if (w_cap) begin
        r_buf   <= imem_rdata;
        r_state <= ST_HELD;
      end
      if (r_valid_d && w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc_f;
  assign pc_f        = r_pc_f;
  assign ir_d        = r_fd.ir;
  assign pc_d        = r_fd.pc;
  assign pc4_d       = r_fd.pc + 32'd4;
  assign pc8_d       = r_fd.pc + 32'd8;
  assign valid_d     = r_valid_d;
  assign fetch_stall = w_req && !imem_ready;
  assign npc_err     = r_err;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed scoreboard bench for fetch_seq: stimulus pushes
// expected per-cycle state, a negedge monitor pops and compares.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_d = 1'b0;
  logic [2:0]  npc_op_d = 3'b000;
  logic        cmp_zero_d = 1'b0;
  logic [31:0] gpr_rs_d = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f, ir_d, pc_d, pc4_d, pc8_d;
  logic        valid_d, fetch_stall, npc_err;
  logic        garble = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc_f;
    logic        v;
    logic [31:0] pc_d;
    logic [31:0] ir;
    logic        fs;
    logic        req;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .stall_d     (stall_d),
    .npc_op_d    (npc_op_d),
    .cmp_zero_d  (cmp_zero_d),
    .gpr_rs_d    (gpr_rs_d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .ir_d        (ir_d),
    .pc_d        (pc_d),
    .pc4_d       (pc4_d),
    .pc8_d       (pc8_d),
    .valid_d     (valid_d),
    .fetch_stall (fetch_stall),
    .npc_err     (npc_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h3000: return 32'h1000_0003;
      32'h3004: return 32'h0800_0C10;
      32'h3008: return 32'h03E0_0008;
      32'h300C: return 32'h2000_000C;
      32'h3010: return 32'h2400_0010;
      default:  return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  // garble corrupts the bus so a HELD release must use the buffer
  always_comb begin
    imem_rdata = mem_word(imem_addr);
    if (garble) imem_rdata = ~imem_rdata;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc_f", pc_f, e.pc_f);
      chk("imem_addr", imem_addr, e.pc_f);
      chk("valid_d", {31'b0, valid_d}, {31'b0, e.v});
      chk("pc_d", pc_d, e.pc_d);
      chk("pc4_d", pc4_d, e.pc_d + 32'd4);
      chk("pc8_d", pc8_d, e.pc_d + 32'd8);
      chk("ir_d", ir_d, e.ir);
      chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, e.fs});
      chk("imem_req", {31'b0, imem_req}, {31'b0, e.req});
      chk("npc_err", {31'b0, npc_err}, {31'b0, e.err});
    end
  end

  task automatic step(input int st, input int op, input int cz,
                      input logic [31:0] rs, input int rdy, input int gb,
                      input logic [31:0] epc, input int ev,
                      input logic [31:0] epd, input int efs,
                      input int ereq, input int eerr);
    exp_t e;
    stall_d    = (st != 0);
    npc_op_d   = op[2:0];
    cmp_zero_d = (cz != 0);
    gpr_rs_d   = rs;
    imem_ready = (rdy != 0);
    garble     = (gb != 0);
    e.pc_f = epc;
    e.v    = (ev != 0);
    e.pc_d = epd;
    e.ir   = (ev != 0) ? mem_word(epd) : 32'h0;
    e.fs   = (efs != 0);
    e.req  = (ereq != 0);
    e.err  = (eerr != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    stall_d    = 1'b0;
    npc_op_d   = 3'b000;
    imem_ready = 1'b1;
    garble     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset(2);
    // sequential, zero-wait
    step(0,0,0,0,1,0, 32'h3000,0,32'h0,   0,1,0);
    step(0,0,0,0,1,0, 32'h3004,1,32'h3000,0,1,0);
    step(0,0,0,0,1,0, 32'h3008,1,32'h3004,0,1,0);
    step(0,0,0,0,1,0, 32'h300C,1,32'h3008,0,1,0);
    // taken branch with delay slot
    do_reset(1);
    step(0,0,0,0,1,0, 32'h3000,0,32'h0,   0,1,0);
    step(0,1,1,0,1,0, 32'h3004,1,32'h3000,0,1,0);
    step(0,0,0,0,1,0, 32'h3010,1,32'h3004,0,1,0);
    step(0,0,0,0,1,0, 32'h3014,1,32'h3010,0,1,0);
    // not taken, then j, then jr
    do_reset(1);
    step(0,0,0,0,1,0, 32'h3000,0,32'h0,   0,1,0);
    step(0,1,0,0,1,0, 32'h3004,1,32'h3000,0,1,0);
    step(0,2,0,0,1,0, 32'h3008,1,32'h3004,0,1,0);
    step(0,3,0,32'h3100,1,0, 32'h3040,1,32'h3008,0,1,0);
    step(0,0,0,0,1,0, 32'h3100,1,32'h3040,0,1,0);
    step(0,0,0,0,1,0, 32'h3104,1,32'h3100,0,1,0);
    // memory wait, stall into HELD, release, reset in HELD
    do_reset(1);
    step(0,0,0,0,1,0, 32'h3000,0,32'h0,   0,1,0);
    step(0,0,0,0,1,0, 32'h3004,1,32'h3000,0,1,0);
    step(0,0,0,0,0,0, 32'h3008,1,32'h3004,1,1,0);
    step(0,0,0,0,0,0, 32'h3008,1,32'h3004,1,1,0);
    step(0,0,0,0,0,0, 32'h3008,1,32'h3004,1,1,0);
    step(0,0,0,0,1,0, 32'h3008,1,32'h3004,0,1,0);
    step(1,0,0,0,1,0, 32'h300C,1,32'h3008,0,1,0);
    step(1,0,0,0,1,1, 32'h300C,1,32'h3008,0,0,0);
    step(0,0,0,0,0,1, 32'h300C,1,32'h3008,0,0,0);
    step(1,0,0,0,1,0, 32'h3010,1,32'h300C,0,1,0);
    step(1,0,0,0,1,0, 32'h3010,1,32'h300C,0,0,0);
    do_reset(1);
    // illegal op: ignored while D invalid, sticky once seen
    step(0,5,0,0,1,0, 32'h3000,0,32'h0,   0,1,0);
    step(0,5,0,0,1,0, 32'h3004,1,32'h3000,0,1,0);
    step(0,0,0,0,1,0, 32'h3008,1,32'h3004,0,1,1);
    step(0,0,0,0,1,0, 32'h300C,1,32'h3008,0,1,1);
    step(1,0,0,0,1,0, 32'h3010,1,32'h300C,0,1,1);
    step(1,0,0,0,1,0, 32'h3010,1,32'h300C,0,0,1);
    do_reset(1);
    step(0,0,0,0,1,0, 32'h3000,0,32'h0,   0,1,0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
